// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: operand forwarding and stall/flush control for a 5-stage RISC-V pipeline
//   inputs : ID/EX/MEM/WB register ids and write enables, load flag, branch_taken, dmem_req/dmem_ready
//   outputs: forward_a/b selects, per-register stalls and flushes, FSM state, stall/flush counters, sticky mem_timeout
module hazard_forward_unit #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       hazard_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             mem_timeout
);
  typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MEM_WAIT = 2'd2} state_t;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);
  state_t state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic timeout_q;
  logic mem_busy, load_use, lu_eff;
  function automatic logic [1:0] fwd(input logic [4:0] rs, input logic mw, input logic [4:0] mrd,
                                     input logic ww, input logic [4:0] wrd);
    return (mw && mrd != 5'd0 && mrd == rs) ? 2'b10 :
           (ww && wrd != 5'd0 && wrd == rs) ? 2'b01 : 2'b00;
  endfunction
  assign mem_busy = dmem_req & ~dmem_ready;
  assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                    ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  // the interlock bubble is already in flight while in LOAD_STALL, so don't re-stall
  assign lu_eff = load_use & (state_q != LOAD_STALL);
  always_comb begin
    forward_a    = rst ? 2'b00 : fwd(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    forward_b    = rst ? 2'b00 : fwd(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    pc_stall     = ~rst & (mem_busy | (~branch_taken & lu_eff));
    if_id_stall  = pc_stall;
    id_ex_stall  = ~rst & mem_busy;
    ex_mem_stall = ~rst & mem_busy;
    if_id_flush  = ~rst & ~mem_busy & branch_taken;
    id_ex_flush  = ~rst & ~mem_busy & (branch_taken | lu_eff);
    state_d      = mem_busy ? MEM_WAIT : (lu_eff & ~branch_taken) ? LOAD_STALL : RUN;
    // first busy cycle counts even though the FSM is still entering MEM_WAIT
    wait_d       = ~mem_busy ? '0 : (wait_q == TMO) ? wait_q : wait_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      stall_q   <= '0;
      flush_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      stall_q   <= stall_q + CNT_W'(pc_stall);
      flush_q   <= flush_q + CNT_W'(if_id_flush);
      timeout_q <= timeout_q | (wait_d == TMO);
    end
  end
  assign hazard_state = state_q;
  assign stall_count  = stall_q;
  assign flush_count  = flush_q;
  assign mem_timeout  = timeout_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed vectors checked against a per-cycle expected queue
module tb_hazard_forward_unit;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_uses_rs1, id_uses_rs2, ex_mem_read, mem_reg_write, wb_reg_write;
  logic branch_taken, dmem_req, dmem_ready;
  logic [1:0] forward_a, forward_b, hazard_state;
  logic pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush, mem_timeout;
  logic [31:0] stall_count, flush_count;
  typedef struct {
    string       name;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [5:0]  ctrl;
    logic [1:0]  st;
    logic [31:0] sc;
    logic [31:0] fc;
    logic        to;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  localparam logic [5:0] NONE = 6'b000000, ALL = 6'b111100, BR = 6'b000011, LU = 6'b110001;
  hazard_forward_unit #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .forward_a(forward_a), .forward_b(forward_b),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .hazard_state(hazard_state),
    .stall_count(stall_count), .flush_count(flush_count), .mem_timeout(mem_timeout)
  );
  always #5 clk = ~clk;
  function automatic void chk(string n, string f, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s actual=%0h expected=%0h", n, f, act, exp);
    end
  endfunction
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "forward_a", 32'(forward_a), 32'(e.fa));
      chk(e.name, "forward_b", 32'(forward_b), 32'(e.fb));
      chk(e.name, "ctrl", 32'({pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush}), 32'(e.ctrl));
      chk(e.name, "state", 32'(hazard_state), 32'(e.st));
      chk(e.name, "stall_count", stall_count, e.sc);
      chk(e.name, "flush_count", flush_count, e.fc);
      chk(e.name, "mem_timeout", 32'(mem_timeout), 32'(e.to));
    end
  end
  task automatic cyc(string n, logic [1:0] fa, logic [1:0] fb, logic [5:0] c, logic [1:0] st,
                     int sc, int fc, logic to);
    exp_t e;
    e.name = n; e.fa = fa; e.fb = fb; e.ctrl = c; e.st = st;
    e.sc = 32'(sc); e.fc = 32'(fc); e.to = to;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask
  task automatic clear();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_mem_read, mem_reg_write, wb_reg_write} = '0;
    {branch_taken, dmem_req, dmem_ready} = '0;
  endtask
  initial begin
    clear();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1; dmem_req = 1; branch_taken = 1;
    cyc("reset", 2'b00, 2'b00, NONE, 0, 0, 0, 0);
    rst = 1'b0; clear();
    ex_rs1 = 5; ex_rs2 = 3; mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1;
    cyc("fwd_a_mem", 2'b10, 2'b00, NONE, 0, 0, 0, 0);
    mem_reg_write = 0;
    cyc("fwd_a_wb", 2'b01, 2'b00, NONE, 0, 0, 0, 0);
    ex_rs1 = 0; ex_rs2 = 5; mem_reg_write = 1;
    cyc("fwd_b_mem", 2'b00, 2'b10, NONE, 0, 0, 0, 0);
    ex_rs2 = 0; mem_rd = 0; wb_rd = 0;
    cyc("fwd_x0", 2'b00, 2'b00, NONE, 0, 0, 0, 0);
    ex_rs2 = 9; wb_rd = 9; mem_rd = 4;
    cyc("fwd_b_wb", 2'b00, 2'b01, NONE, 0, 0, 0, 0);
    clear();
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 1;
    cyc("lu_stall", 2'b00, 2'b00, LU, 0, 0, 0, 0);
    cyc("lu_masked", 2'b00, 2'b00, NONE, 1, 1, 0, 0);
    clear();
    cyc("lu_done", 2'b00, 2'b00, NONE, 0, 1, 0, 0);
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 0;
    cyc("lu_unused1", 2'b00, 2'b00, NONE, 0, 1, 0, 0);
    cyc("lu_unused2", 2'b00, 2'b00, NONE, 0, 1, 0, 0);
    id_uses_rs2 = 1; branch_taken = 1;
    cyc("br_over_lu", 2'b00, 2'b00, BR, 0, 1, 0, 0);
    clear();
    cyc("br_after", 2'b00, 2'b00, NONE, 0, 1, 1, 0);
    dmem_req = 1; branch_taken = 1;
    cyc("mw1", 2'b00, 2'b00, ALL, 0, 1, 1, 0);
    cyc("mw2", 2'b00, 2'b00, ALL, 2, 2, 1, 0);
    cyc("mw3", 2'b00, 2'b00, ALL, 2, 3, 1, 0);
    dmem_ready = 1;
    cyc("mw_ready", 2'b00, 2'b00, BR, 2, 4, 1, 0);
    clear();
    cyc("mw_after", 2'b00, 2'b00, NONE, 0, 4, 2, 0);
    dmem_req = 1;
    cyc("to1", 2'b00, 2'b00, ALL, 0, 4, 2, 0);
    cyc("to2", 2'b00, 2'b00, ALL, 2, 5, 2, 0);
    cyc("to3", 2'b00, 2'b00, ALL, 2, 6, 2, 0);
    cyc("to4", 2'b00, 2'b00, ALL, 2, 7, 2, 0);
    cyc("to_set", 2'b00, 2'b00, ALL, 2, 8, 2, 1);
    cyc("to_sticky", 2'b00, 2'b00, ALL, 2, 9, 2, 1);
    rst = 1; ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1;
    cyc("rst_midwait", 2'b00, 2'b00, NONE, 2, 10, 2, 1);
    rst = 0; clear();
    cyc("post_rst", 2'b00, 2'b00, NONE, 0, 0, 0, 0);
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_uses_rs1 = 1;
    cyc("lu_x0", 2'b00, 2'b00, NONE, 0, 0, 0, 0);
    clear();
    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
